// File: rtl/rggen_access_arbiter.sv
// rtl/rggen_access_arbiter.sv - round-robin arbiter sharing one register-block port between N_HOSTS hosts
// The grant is held from request until the register block returns ready.
module rggen_access_arbiter #(
  parameter int N_HOSTS       = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [N_HOSTS-1:0]               i_host_valid,
  input  logic [N_HOSTS*2-1:0]             i_host_access,
  input  logic [N_HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [N_HOSTS*BUS_WIDTH-1:0]     i_host_write_data,
  input  logic [N_HOSTS*BUS_WIDTH/8-1:0]   i_host_strobe,
  output logic [N_HOSTS-1:0]               o_host_ready,
  output logic [1:0]                       o_host_status,
  output logic [BUS_WIDTH-1:0]             o_host_read_data,
  output logic                             o_reg_valid,
  output logic [1:0]                       o_reg_access,
  output logic [ADDRESS_WIDTH-1:0]         o_reg_address,
  output logic [BUS_WIDTH-1:0]             o_reg_write_data,
  output logic [BUS_WIDTH/8-1:0]           o_reg_strobe,
  input  logic                             i_reg_ready,
  input  logic [1:0]                       i_reg_status,
  input  logic [BUS_WIDTH-1:0]             i_reg_read_data
);
  localparam int IDX_W  = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;
  localparam int STRB_W = BUS_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state, w_state_nxt;
  logic [N_HOSTS-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  logic [2*N_HOSTS-1:0] w_req_rot;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic                 w_busy;
  logic                 w_done;

  // (base + off) mod N_HOSTS; both operands are already below N_HOSTS
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + (IDX_W+1)'(off);
    if (s >= (IDX_W+1)'(N_HOSTS)) s = s - (IDX_W+1)'(N_HOSTS);
    return s[IDX_W-1:0];
  endfunction

  // Rotate requests so bit 0 is the host at the pointer, then take the first set bit
  assign w_req_rot = {i_host_valid, i_host_valid} >> r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < N_HOSTS; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_ptr, i);
      end
    end
  end

  assign w_busy = (r_state == BUSY) && !i_rst;
  assign w_done = w_busy && i_reg_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = BUSY;
          w_grant_idx_nxt = w_pick;
          for (int i = 0; i < N_HOSTS; i++) w_grant_nxt[i] = (w_pick == IDX_W'(i));
        end
      end
      BUSY: begin
        if (i_reg_ready) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = wrap_add(r_grant_idx, 1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  // One-hot grant makes an AND-OR mux sufficient; grant is cleared outside BUSY
  always_comb begin
    o_reg_access     = '0;
    o_reg_address    = '0;
    o_reg_write_data = '0;
    o_reg_strobe     = '0;
    for (int i = 0; i < N_HOSTS; i++) begin
      if (r_grant[i]) begin
        o_reg_access     = o_reg_access     | i_host_access[2*i +: 2];
        o_reg_address    = o_reg_address    | i_host_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
        o_reg_write_data = o_reg_write_data | i_host_write_data[BUS_WIDTH*i +: BUS_WIDTH];
        o_reg_strobe     = o_reg_strobe     | i_host_strobe[STRB_W*i +: STRB_W];
      end
    end
  end

  assign o_reg_valid      = w_busy;
  assign o_host_ready     = w_done ? r_grant : '0;
  assign o_host_status    = w_done ? i_reg_status : 2'b00;
  assign o_host_read_data = w_done ? i_reg_read_data : '0;
endmodule

// File: tb/tb_rggen_access_arbiter.sv
// tb/tb_rggen_access_arbiter.sv - directed bench for rggen_access_arbiter with four hosts
module tb_rggen_access_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int BW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    host_valid;
  logic [N*2-1:0]  host_access;
  logic [N*AW-1:0] host_address;
  logic [N*BW-1:0] host_wdata;
  logic [N*BW/8-1:0] host_strobe;
  logic [N-1:0]    host_ready;
  logic [1:0]      host_status;
  logic [BW-1:0]   host_rdata;
  logic            reg_valid;
  logic [1:0]      reg_access;
  logic [AW-1:0]   reg_address;
  logic [BW-1:0]   reg_wdata;
  logic [BW/8-1:0] reg_strobe;
  logic            reg_ready;
  logic [1:0]      reg_status;
  logic [BW-1:0]   reg_rdata;

  int vectors = 0;
  int miscompares = 0;

  rggen_access_arbiter #(.N_HOSTS(N), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(host_valid), .i_host_access(host_access), .i_host_address(host_address),
    .i_host_write_data(host_wdata), .i_host_strobe(host_strobe),
    .o_host_ready(host_ready), .o_host_status(host_status), .o_host_read_data(host_rdata),
    .o_reg_valid(reg_valid), .o_reg_access(reg_access), .o_reg_address(reg_address),
    .o_reg_write_data(reg_wdata), .o_reg_strobe(reg_strobe),
    .i_reg_ready(reg_ready), .i_reg_status(reg_status), .i_reg_read_data(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host(input int h, input logic v, input logic [1:0] acc, input logic [AW-1:0] addr,
                      input logic [BW-1:0] d, input logic [3:0] s);
    host_valid[h]           = v;
    host_access[h*2 +: 2]   = acc;
    host_address[h*AW +: AW] = addr;
    host_wdata[h*BW +: BW]  = d;
    host_strobe[h*4 +: 4]   = s;
  endtask

  initial begin
    logic [3:0] exp_oh;
    rst = 1'b1;
    host_valid = '0; host_access = '0; host_address = '0; host_wdata = '0; host_strobe = '0;
    for (int h = 0; h < N; h++) host(h, 1'b1, 2'b00, 8'h40 + 8'(h), 32'h1000 + 32'(h), 4'hF);
    reg_ready = 1'b1; reg_status = 2'b11; reg_rdata = 32'hFFFF_FFFF;

    // reset held three cycles with every host requesting
    repeat (3) begin
      tick();
      chk("rst_reg_valid", reg_valid, 0);
      chk("rst_host_ready", host_ready, 0);
    end
    rst = 1'b0; reg_ready = 1'b0;
    tick();
    chk("rst_first_valid", reg_valid, 1);
    chk("rst_first_grant", reg_address, 8'h40);
    reg_ready = 1'b1; reg_status = 2'b00; #1;
    chk("rst_first_ready", host_ready, 4'b0001);
    tick();
    host_valid = '0; reg_ready = 1'b0; #1;
    chk("idle_reg_valid", reg_valid, 0);
    chk("idle_read_data", host_rdata, 0);

    // single write from host1
    host(1, 1'b1, 2'b01, 8'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk("wr_valid_t1", reg_valid, 1);
    chk("wr_addr_t1", reg_address, 8'h10);
    chk("wr_wdata", reg_wdata, 32'hDEAD_BEEF);
    chk("wr_access", reg_access, 2'b01);
    chk("wr_strobe", reg_strobe, 4'hF);
    chk("wr_no_ready_t1", host_ready, 0);
    tick();
    chk("wr_addr_t2", reg_address, 8'h10);
    chk("wr_no_ready_t2", host_ready, 0);
    tick();
    reg_ready = 1'b1; #1;
    chk("wr_ready", host_ready, 4'b0010);
    tick();
    host_valid[1] = 1'b0; reg_ready = 1'b0; #1;
    chk("wr_ready_once", host_ready, 0);

    // read routed to host0 while host1 waits
    host(0, 1'b1, 2'b00, 8'h20, 32'h0, 4'h0);
    host(1, 1'b1, 2'b00, 8'h21, 32'h0, 4'h0);
    tick();
    chk("rd_grant", reg_address, 8'h20);
    reg_ready = 1'b1; reg_status = 2'b01; reg_rdata = 32'hA5A5_0001; #1;
    chk("rd_ready", host_ready, 4'b0001);
    chk("rd_data", host_rdata, 32'hA5A5_0001);
    chk("rd_status", host_status, 2'b01);
    tick();
    host_valid[0] = 1'b0; reg_ready = 1'b0; #1;
    chk("rd_idle_status", host_status, 0);
    chk("rd_host1_no_ready", host_ready, 0);
    tick();
    chk("rd_host1_grant", reg_address, 8'h21);
    reg_ready = 1'b1; reg_status = 2'b00; #1;
    chk("rd_host1_ready", host_ready, 4'b0010);
    tick();
    host_valid[1] = 1'b0; reg_ready = 1'b0;

    // host2 alone moves the pointer to 3
    host(2, 1'b1, 2'b00, 8'h32, 32'h0, 4'h0);
    tick();
    chk("h2_grant", reg_address, 8'h32);
    reg_ready = 1'b1; #1;
    chk("h2_ready", host_ready, 4'b0100);
    tick();
    host_valid[2] = 1'b0; reg_ready = 1'b0;

    // stall: host0 granted, host2 waits through 10 withheld-ready cycles
    host(0, 1'b1, 2'b01, 8'h50, 32'h0000_5050, 4'h3);
    host(2, 1'b1, 2'b00, 8'h52, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_addr", reg_address, 8'h50);
      chk("stall_no_ready", host_ready, 0);
      tick();
    end
    reg_ready = 1'b1; #1;
    chk("stall_ready", host_ready, 4'b0001);
    chk("stall_strobe", reg_strobe, 4'h3);
    tick();
    host_valid[0] = 1'b0; reg_ready = 1'b0;
    tick();
    chk("stall_h2_grant", reg_address, 8'h52);
    reg_ready = 1'b1; #1;
    chk("stall_h2_ready", host_ready, 4'b0100);
    tick();
    host_valid[2] = 1'b0; reg_ready = 1'b0;

    // reset in the middle of host1's access
    host(1, 1'b1, 2'b00, 8'h61, 32'h0, 4'h0);
    tick();
    chk("mid_grant", reg_address, 8'h61);
    rst = 1'b1; reg_ready = 1'b1; #1;
    chk("mid_rst_no_ready", host_ready, 0);
    chk("mid_rst_no_valid", reg_valid, 0);
    tick();
    rst = 1'b0; reg_ready = 1'b0;
    for (int h = 0; h < N; h++) host(h, 1'b1, 2'b00, 8'h70 + 8'(h), 32'h0, 4'h0);
    #1;
    chk("mid_idle_valid", reg_valid, 0);
    chk("mid_idle_ready", host_ready, 0);

    // round robin from a reset pointer: 0,1,2,3,0 with one IDLE cycle between
    for (int g = 0; g < 5; g++) begin
      tick();
      exp_oh = 4'b0001 << (g % 4);
      chk("rr_addr", reg_address, 8'h70 + 8'(g % 4));
      reg_ready = 1'b1; #1;
      chk("rr_ready", host_ready, exp_oh);
      tick();
      reg_ready = 1'b0; #1;
      chk("rr_idle", reg_valid, 0);
    end
    host_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
